// File: rtl/motion_seg_queue.sv
// motion_seg_queue: segment queue and loader in front of the multi-axis motor controller.
// Builds records from a 32-bit host word stream, buffers up to DEPTH records and issues
// them one at a time to the controller using its per-motor wrreq status as the handshake.
//
// Record word order: header (mask in low MOTORS bits), task id, then N, T for each set mask bit
// in ascending motor order. Motors with a clear mask bit get N = T = 0.
//
// Ports:
//   clk, aclr_n         clock, asynchronous active-low reset
//   sclr                synchronous clear: flush queue, zero N/T/task_id, clear err
//   abort               synchronous flush; keeps N/T/task_id and err
//   in_valid/in_data    host word stream, accepted when in_valid && in_ready
//   in_ready            high while a record slot is free
//   N, T, task_id       issued segment, motor m at bits [32*m +: 32]
//   write               per-motor load request to the controller
//   wrreq               per-motor controller "segment loaded/active" status
//   busy                queue non-empty or a segment in flight
//   err                 sticky: zero-mask header received
//   level               buffered record count
//
// Build option: define MOTION_SEG_QUEUE_LEVEL_EN to report the live record count on level;
// otherwise level is tied to zero.

module motion_seg_queue #(
    parameter int unsigned MOTORS = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   sclr,
    input  logic                   abort,
    input  logic                   in_valid,
    input  logic [31:0]            in_data,
    output logic                   in_ready,
    output logic [MOTORS*32-1:0]   N,
    output logic [MOTORS*32-1:0]   T,
    output logic [31:0]            task_id,
    output logic [MOTORS-1:0]      write,
    input  logic [MOTORS-1:0]      wrreq,
    output logic                   busy,
    output logic                   err,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned IW = (MOTORS > 1) ? $clog2(MOTORS) : 1;

    typedef enum logic [1:0] {AsmHdr, AsmId, AsmData} asm_e;
    typedef enum logic [1:0] {IssIdle, IssIssue, IssBusy} iss_e;

    // Record storage
    logic [MOTORS-1:0]    mem_mask [DEPTH];
    logic [31:0]          mem_task [DEPTH];
    logic [MOTORS*32-1:0] mem_n    [DEPTH];
    logic [MOTORS*32-1:0] mem_t    [DEPTH];

    asm_e              asm_q, asm_d;
    iss_e              iss_q, iss_d;
    logic [MOTORS-1:0] mask_q, mask_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              ph_q, ph_d;      // 0: expecting N, 1: expecting T
    logic [PW-1:0]     head_q, tail_q;
    logic [LW-1:0]     count_q;
    logic              err_q;
    logic [MOTORS-1:0] wmask_q;
    logic [MOTORS*32-1:0] n_q, t_q;
    logic [31:0]       task_q;

    logic              flush, accept, commit, err_set, pop;
    logic [MOTORS-1:0] hdr_mask;
    logic [IW-1:0]     first_idx, nxt_idx;
    logic              nxt_found;

    assign flush    = sclr | abort;
    assign in_ready = (count_q != LW'(DEPTH));
    assign accept   = in_valid & in_ready;
    assign hdr_mask = in_data[MOTORS-1:0];

    // Lowest set bit of an incoming header, and next set mask bit above the current motor.
    always_comb begin
        first_idx = '0;
        nxt_idx   = '0;
        nxt_found = 1'b0;
        for (int i = int'(MOTORS) - 1; i >= 0; i--) begin
            if (hdr_mask[i]) first_idx = IW'(i);
            if (mask_q[i] && (i > int'(idx_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = IW'(i);
            end
        end
    end

    // Assembler next state
    always_comb begin
        asm_d   = asm_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        commit  = 1'b0;
        err_set = 1'b0;
        if (accept) begin
            case (asm_q)
                AsmHdr: begin
                    if (hdr_mask == '0) begin
                        err_set = 1'b1;
                    end else begin
                        asm_d  = AsmId;
                        mask_d = hdr_mask;
                        idx_d  = first_idx;
                        ph_d   = 1'b0;
                    end
                end
                AsmId:   asm_d = AsmData;
                AsmData: begin
                    if (!ph_q) begin
                        ph_d = 1'b1;
                    end else begin
                        ph_d = 1'b0;
                        if (nxt_found) begin
                            idx_d = nxt_idx;
                        end else begin
                            commit = 1'b1;
                            asm_d  = AsmHdr;
                        end
                    end
                end
                default: asm_d = AsmHdr;
            endcase
        end
        // A flush drops any record being built, including one committing this cycle.
        if (flush) begin
            asm_d  = AsmHdr;
            commit = 1'b0;
        end
    end

    // The tail slot is free for the whole time a record is being built, so words are
    // written straight into it; commit only advances the tail.
    always_ff @(posedge clk) begin
        if (accept) begin
            case (asm_q)
                AsmHdr: begin
                    if (hdr_mask != '0) begin
                        mem_mask[tail_q] <= hdr_mask;
                        mem_n[tail_q]    <= '0;
                        mem_t[tail_q]    <= '0;
                    end
                end
                AsmId: mem_task[tail_q] <= in_data;
                AsmData: begin
                    if (!ph_q) mem_n[tail_q][32*idx_q +: 32] <= in_data;
                    else       mem_t[tail_q][32*idx_q +: 32] <= in_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            asm_q   <= AsmHdr;
            mask_q  <= '0;
            idx_q   <= '0;
            ph_q    <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            mask_q <= mask_d;
            idx_q  <= idx_d;
            ph_q   <= ph_d;
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (commit) tail_q <= tail_q + PW'(1);
                if (pop)    head_q <= head_q + PW'(1);
                count_q <= count_q + LW'(commit) - LW'(pop);
            end
            if (sclr)         err_q <= 1'b0;
            else if (err_set) err_q <= 1'b1;
        end
    end

    // Issue FSM: state register
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) iss_q <= IssIdle;
        else         iss_q <= iss_d;
    end

    // Issue FSM: next state
    always_comb begin
        iss_d = iss_q;
        pop   = 1'b0;
        case (iss_q)
            IssIdle: begin
                if ((count_q != '0) && (wrreq == '0)) begin
                    iss_d = IssIssue;
                    pop   = 1'b1;
                end
            end
            IssIssue: if (wrreq != '0) iss_d = IssBusy;
            IssBusy:  if (wrreq == '0) iss_d = IssIdle;
            default:  iss_d = IssIdle;
        endcase
        if (flush) begin
            iss_d = IssIdle;
            pop   = 1'b0;
        end
    end

    // Issue FSM: outputs
    always_comb begin
        write = (iss_q == IssIssue) ? wmask_q : '0;
        busy  = (count_q != '0) || (iss_q != IssIdle);
    end

    // Issued segment registers hold until the next issue or sclr.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            n_q     <= '0;
            t_q     <= '0;
            task_q  <= '0;
            wmask_q <= '0;
        end else if (sclr) begin
            n_q     <= '0;
            t_q     <= '0;
            task_q  <= '0;
            wmask_q <= '0;
        end else if (pop) begin
            n_q     <= mem_n[head_q];
            t_q     <= mem_t[head_q];
            task_q  <= mem_task[head_q];
            wmask_q <= mem_mask[head_q];
        end
    end

    assign N       = n_q;
    assign T       = t_q;
    assign task_id = task_q;
    assign err     = err_q;

`ifdef MOTION_SEG_QUEUE_LEVEL_EN
    assign level = count_q;
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_motion_seg_queue.sv
module tb_motion_seg_queue;

    localparam int unsigned MOTORS = 2;
    localparam int unsigned DEPTH  = 4;

    logic                 clk = 1'b0;
    logic                 aclr_n = 1'b0;
    logic                 sclr = 1'b0;
    logic                 abort = 1'b0;
    logic                 in_valid = 1'b0;
    logic [31:0]          in_data = '0;
    logic                 in_ready;
    logic [MOTORS*32-1:0] N;
    logic [MOTORS*32-1:0] T;
    logic [31:0]          task_id;
    logic [MOTORS-1:0]    write;
    logic [MOTORS-1:0]    wrreq = '0;
    logic                 busy;
    logic                 err;
    logic [2:0]           level;

    int checks = 0;
    int errors = 0;

    motion_seg_queue #(.MOTORS(MOTORS), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .aclr_n   (aclr_n),
        .sclr     (sclr),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .N        (N),
        .T        (T),
        .task_id  (task_id),
        .write    (write),
        .wrreq    (wrreq),
        .busy     (busy),
        .err      (err),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected level output: live count only when the reporting option is built in.
    function automatic logic [2:0] lvl(input int n);
`ifdef MOTION_SEG_QUEUE_LEVEL_EN
        return 3'(n);
`else
        return 3'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] pair(input logic [31:0] m1, input logic [31:0] m0);
        return {m1, m0};
    endfunction

    // Called right after the last word of a record is accepted, queue otherwise empty.
    task automatic issue_check(input logic [1:0] ew, input logic [63:0] en, input logic [63:0] et,
                               input logic [31:0] eid);
        check("pre_issue_write", 64'(write), 64'd0);
        check("pre_issue_busy", 64'(busy), 64'd1);
        check("pre_issue_level", 64'(level), 64'(lvl(1)));
        step();
        check("issue_write", 64'(write), 64'(ew));
        check("issue_N", N, en);
        check("issue_T", T, et);
        check("issue_task", 64'(task_id), 64'(eid));
        check("issue_level", 64'(level), 64'(lvl(0)));
        step();
        check("write_2nd_cycle", 64'(write), 64'(ew));
        wrreq = ew;
        step();
        check("write_drop", 64'(write), 64'd0);
        check("busy_inflight", 64'(busy), 64'd1);
        wrreq = '0;
        step();
        check("busy_done", 64'(busy), 64'd0);
        check("N_held", N, en);
    endtask

    task automatic drain_one(input logic [31:0] eid, input logic [63:0] en);
        int n;
        n = 0;
        while (write == '0 && n < 50) begin
            step();
            n++;
        end
        check("drain_write", 64'(write), 64'd1);
        check("drain_task", 64'(task_id), 64'(eid));
        check("drain_N", N, en);
        wrreq = write;
        step();
        check("drain_drop", 64'(write), 64'd0);
        wrreq = '0;
        step();
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_write", 64'(write), 64'd0);
        check("rst_N", N, 64'd0);
        check("rst_T", T, 64'd0);
        check("rst_task", 64'(task_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        step();
        aclr_n = 1'b1;
        step();

        // Two-motor record
        send_word(32'h3); send_word(32'h55);
        send_word(32'd10); send_word(32'd100); send_word(32'd20); send_word(32'd200);
        issue_check(2'b11, pair(32'd20, 32'd10), pair(32'd200, 32'd100), 32'h55);

        // Motor 1 only; upper header bits ignored
        send_word(32'hFFFF_FFF2); send_word(32'h77);
        send_word(32'd33); send_word(32'd333);
        issue_check(2'b10, pair(32'd33, 32'd0), pair(32'd333, 32'd0), 32'h77);

        // Zero-mask header sets err, next header parses normally, sclr clears
        send_word(32'h0);
        check("err_set", 64'(err), 64'd1);
        check("err_no_record", 64'(busy), 64'd0);
        send_word(32'h1); send_word(32'h9); send_word(32'd5); send_word(32'd50);
        issue_check(2'b01, pair(32'd0, 32'd5), pair(32'd0, 32'd50), 32'h9);
        check("err_sticky", 64'(err), 64'd1);
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        check("sclr_err", 64'(err), 64'd0);
        check("sclr_N", N, 64'd0);
        check("sclr_T", T, 64'd0);
        check("sclr_task", 64'(task_id), 64'd0);

        // Fill the queue while the controller reports active
        wrreq = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            send_word(32'h1); send_word(32'(k)); send_word(32'(k)); send_word(32'(10 * k));
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_level", 64'(level), 64'(lvl(4)));
        check("full_no_issue", 64'(write), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'h1;
        step();
        step();
        check("full_hold_ready", 64'(in_ready), 64'd0);
        wrreq = '0;
        step();
        check("pop_frees_slot", 64'(in_ready), 64'd1);
        check("pop_issue_task", 64'(task_id), 64'd1);
        send_word(32'h1); send_word(32'd5); send_word(32'd5); send_word(32'd50);
        check("refill_level", 64'(level), 64'(lvl(4)));
        for (int k = 1; k <= 5; k++) drain_one(32'(k), pair(32'd0, 32'(k)));
        check("drained_busy", 64'(busy), 64'd0);

        // Abort with two records queued and a third partial
        wrreq = 2'b11;
        for (int k = 0; k < 2; k++) begin
            send_word(32'h3); send_word(32'hB0 + 32'(k));
            send_word(32'd1); send_word(32'd2); send_word(32'd3); send_word(32'd4);
        end
        send_word(32'h3); send_word(32'hBB); send_word(32'd7);
        check("pre_abort_level", 64'(level), 64'(lvl(2)));
        check("pre_abort_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_level", 64'(level), 64'(lvl(0)));
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_write", 64'(write), 64'd0);
        check("abort_N_kept", N, pair(32'd0, 32'd5));
        check("abort_task_kept", 64'(task_id), 64'd5);
        wrreq = '0;
        step();
        send_word(32'h3); send_word(32'hA1);
        send_word(32'd1); send_word(32'd2); send_word(32'd3); send_word(32'd4);
        issue_check(2'b11, pair(32'd3, 32'd1), pair(32'd4, 32'd2), 32'hA1);

        // Asynchronous reset while a segment is being issued
        send_word(32'h1); send_word(32'hC3); send_word(32'd8); send_word(32'd80);
        step();
        check("pre_aclr_write", 64'(write), 64'd1);
        #2;
        aclr_n = 1'b0;
        #1;
        check("aclr_write", 64'(write), 64'd0);
        check("aclr_N", N, 64'd0);
        check("aclr_T", T, 64'd0);
        check("aclr_task", 64'(task_id), 64'd0);
        check("aclr_busy", 64'(busy), 64'd0);
        check("aclr_level", 64'(level), 64'd0);
        check("aclr_in_ready", 64'(in_ready), 64'd1);
        step();
        aclr_n = 1'b1;
        step();
        check("post_aclr_ready", 64'(in_ready), 64'd1);
        check("post_aclr_busy", 64'(busy), 64'd0);
        check("post_aclr_write", 64'(write), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/motion_seg_queue.md
# motion_seg_queue

Segment queue and loader directly upstream of the multi-axis motor controller. Accepts motion segments from the host as a 32-bit word stream, assembles them into records (motor mask, task id, per-motor step count N and period T), and buffers up to DEPTH records. Issues one record at a time to the controller's `N`/`T`/`task_id`/`write` inputs using the controller's `wrreq` status as the handshake. Holds issued values stable until the controller finishes the segment.

## Interface
Parameters:
- MOTORS, 8, number of axes; 1..32
- DEPTH, 4, record slots; power of 2, ≥2

Ports:
- clk  in  1  system clock
- aclr_n  in  1  asynchronous reset, active-low
- sclr  in  1  synchronous clear: flush, clear outputs, clear `err`
- abort  in  1  synchronous flush; does not clear `err`
- in_valid  in  1  host word valid
- in_data  in  32  host word
- in_ready  out  1  word accepted when in_valid && in_ready
- N  out  MOTORS×32  step count of issued segment, per motor
- T  out  MOTORS×32  step period of issued segment, per motor
- task_id  out  32  task id of issued segment
- write  out  MOTORS  load request, per motor, to controller
- wrreq  in  MOTORS  controller per-motor "segment loaded/active" status
- busy  out  1  queue non-empty or segment in flight
- err  out  1  sticky: zero-mask header received
- level  out  $clog2(DEPTH)+1  records buffered

## Operation
Record format (word order):
- header: in_data[MOTORS-1:0] = mask; upper bits ignored
- task id
- then for each set mask bit, ascending motor index: N, then T
- N and T of motors with a clear mask bit are stored as 0

Assembler states:
- HDR → ID on an accepted header with mask≠0
- Zero mask: word consumed, `err`←1, stay in HDR
- ID → DATA
- DATA alternates N/T through the set mask bits
- Accepting the last T commits the record to the tail slot and returns to HDR
- in_ready = (level < DEPTH) in every state, so a partial record never stalls waiting for a slot

Issue FSM:
- IDLE: when level≠0 and wrreq=='0, load head record into N/T/task_id output registers, write←head mask, pop head, go to ISSUE
- ISSUE: hold write. When wrreq≠'0, write←0 and go to BUSY
- BUSY: when wrreq=='0 (controller finished or aborted), go to IDLE
- N/T/task_id hold their values from issue until the next issue or a clear
- busy = (level≠0) || (state≠IDLE)

Boundaries:
- Commit and pop in the same cycle: level unchanged; head/tail pointers wrap modulo DEPTH
- Full (level==DEPTH): in_ready=0; the assembler holds its state
- abort: level←0, assembler←HDR, write←0, FSM←IDLE. N/T/task_id retained. abort has priority over a same-cycle commit (that record is lost)
- sclr: same as abort, plus N/T/task_id←0 and err←0
- Reset (aclr_n low): every output 0, except in_ready=1

## Timing
- Final T word accepted at edge E → level increments after E
- If FSM is IDLE and wrreq=='0 at E+1, write and outputs are valid after E+1 (2-cycle latency)
- Controller raises wrreq on the edge following write. write drops on the edge after wrreq≠'0 is sampled
- write is high for exactly 2 cycles on normal handshake
- Next issue occurs no earlier than 1 cycle after wrreq returns to '0

## Configuration
- MOTION_SEG_QUEUE_LEVEL_EN defined: `level` reports the live record count
- MOTION_SEG_QUEUE_LEVEL_EN undefined: `level` tied to 0 and its output register removed; internal full/empty logic unchanged

## Test plan
- MOTORS=2. Send hdr 0x3, id 0x55, N0=10, T0=100, N1=20, T1=200 → write=2'b11, N={20,10}, T={200,100}, task_id=0x55 two cycles after the last word. Model wrreq response → write low after 2 cycles.
- Header mask 0x2 only → N[0]=T[0]=0, N[1]/T[1] from stream, write=2'b10.
- DEPTH=4, hold wrreq high, push 5 records → in_ready=0 after the 4th; the 5th completes after wrreq drops and a pop occurs.
- Header 0x0 → err=1, next header parsed normally; sclr clears err.
- abort mid-record with 2 records queued → level=0, write=0, busy=0; next full record issues normally.
- aclr_n low during ISSUE → all outputs 0, in_ready=1 on release.
